// File: rtl/keyed_cmd_seq_pkg.sv
// Shared types and helpers for the keyed command sequencer.
// The decoy states reuse the genuine low bits with bit 2 set, so both paths stay easy to tell apart.
package keyed_cmd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_DECODE   = 3'b001,
        ST_EXEC     = 3'b010,
        ST_DONE     = 3'b011,
        ST_DECODE_D = 3'b101,
        ST_EXEC_D   = 3'b110,
        ST_DONE_D   = 3'b111
    } state_t;

    // Width of the saturating decoy counter: $clog2(limit+1), never below 1.
    function automatic int cnt_w(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Genuine beat payload: opcode in the upper field, beat index in the lower LEN_W bits.
    function automatic logic [63:0] format_beat(input logic [63:0] op, input logic [63:0] idx,
                                                input int len_w);
        return (op << len_w) | idx;
    endfunction

endpackage

// File: rtl/keyed_cmd_seq_beat_ctr.sv
// Beat index register shared by the genuine and decoy execution paths.
// 'last' flags the final beat of a burst of length len (len==0 never reaches EXEC).
module keyed_cmd_seq_beat_ctr #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] idx,
    output logic             last
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    logic [LEN_W-1:0] idx_reg;
    logic [LEN_W-1:0] idx_next;

    always_comb begin
        idx_next = idx_reg;
        if (load) begin
            idx_next = '0;
        end else if (advance) begin
            idx_next = idx_reg + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_reg <= '0;
        end else begin
            idx_reg <= idx_next;
        end
    end

    assign idx  = idx_reg;
    assign last = (idx_reg == len - ONE);

endmodule

// File: rtl/keyed_cmd_sequencer.sv
// Key-locked command sequencer: expands each accepted command into a burst of beats.
// A wrong key runs a timing-identical decoy path whose data inverts after CORRUPT_AFTER commands.
module keyed_cmd_sequencer
    import keyed_cmd_seq_pkg::*;
#(
    parameter int               KEY_W         = 8,
    parameter logic [KEY_W-1:0] KEY_VAL       = 8'hA5,
    parameter int               CMD_W         = 4,
    parameter int               LEN_W         = 4,
    parameter int               OUT_W         = 8,
    parameter int               CORRUPT_AFTER = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CMD_W-1:0] cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [KEY_W-1:0] keyinput,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy,
    output logic             done
);

    if (OUT_W < CMD_W + LEN_W) begin : g_bad_out_w
        $error("OUT_W must be at least CMD_W+LEN_W");
    end
    if (OUT_W > 64) begin : g_bad_out_max
        $error("OUT_W above 64 is not supported");
    end
    if (CORRUPT_AFTER < 0 || CORRUPT_AFTER > 255) begin : g_bad_corrupt
        $error("CORRUPT_AFTER must lie in 0..255");
    end

    localparam int               CNT_W   = cnt_w(CORRUPT_AFTER);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CORRUPT_AFTER);

    state_t           state_reg, state_next;
    logic [CMD_W-1:0] op_reg;
    logic [LEN_W-1:0] len_reg;
    logic [CNT_W-1:0] decoy_cnt_reg, decoy_cnt_next;

    logic             idx_load, idx_advance, idx_last;
    logic [LEN_W-1:0] idx;
    logic [OUT_W-1:0] genuine_beat;
    logic [OUT_W-1:0] corrupt_mask;
    logic             corrupt;

    keyed_cmd_seq_beat_ctr #(.LEN_W(LEN_W)) u_beat_ctr (
        .clk     (clk),
        .rst     (rst),
        .load    (idx_load),
        .advance (idx_advance),
        .len     (len_reg),
        .idx     (idx),
        .last    (idx_last)
    );

    always_comb begin
        state_next     = state_reg;
        idx_load       = 1'b0;
        idx_advance    = 1'b0;
        decoy_cnt_next = decoy_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = (keyinput == KEY_VAL) ? ST_DECODE : ST_DECODE_D;
                end
            end
            ST_DECODE: begin
                idx_load   = 1'b1;
                state_next = (len_reg == '0) ? ST_DONE : ST_EXEC;
            end
            ST_DECODE_D: begin
                idx_load   = 1'b1;
                state_next = (len_reg == '0) ? ST_DONE_D : ST_EXEC_D;
            end
            ST_EXEC: begin
                if (out_ready) begin
                    idx_advance = 1'b1;
                    if (idx_last) state_next = ST_DONE;
                end
            end
            ST_EXEC_D: begin
                if (out_ready) begin
                    idx_advance = 1'b1;
                    if (idx_last) state_next = ST_DONE_D;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_DONE_D: begin
                state_next = ST_IDLE;
                if (decoy_cnt_reg < CNT_SAT) decoy_cnt_next = decoy_cnt_reg + CNT_W'(1);
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // op/len are captured only at accept so later input changes cannot disturb a burst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            op_reg        <= '0;
            len_reg       <= '0;
            decoy_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            decoy_cnt_reg <= decoy_cnt_next;
            if (state_reg == ST_IDLE && cmd_valid) begin
                op_reg  <= cmd_op;
                len_reg <= cmd_len;
            end
        end
    end

    assign genuine_beat = OUT_W'(format_beat(64'(op_reg), 64'(idx), LEN_W));
    assign corrupt      = (decoy_cnt_reg >= CNT_SAT);

    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_mask
        assign corrupt_mask[gi] = corrupt;
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        case (state_reg)
            ST_EXEC: begin
                out_valid = 1'b1;
                out_data  = genuine_beat;
            end
            ST_EXEC_D: begin
                out_valid = 1'b1;
                out_data  = genuine_beat ^ corrupt_mask;
            end
            default: begin
                out_valid = 1'b0;
                out_data  = '0;
            end
        endcase
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE) || (state_reg == ST_DONE_D);

endmodule

// File: doc/keyed_cmd_sequencer.md
# keyed_cmd_sequencer

Parametrised, key-locked command sequencer: the next generation of our state-duplication locked controllers, with keyed decoy paths. An accepted command is expanded into a burst of output beats. The key is sampled at command accept. A correct key runs the genuine state path. A wrong key runs a duplicated decoy path that is output-identical for the first CORRUPT_AFTER commands and then emits inverted data. Sits between the command front-end and the datapath issue stage.

## Interface
- KEY_W, 8, key width
- KEY_VAL, 8'hA5, correct key value
- CMD_W, 4, opcode width
- LEN_W, 4, burst-length width
- OUT_W, 8, output data width; must be >= CMD_W+LEN_W (elaboration error otherwise)
- CORRUPT_AFTER, 5, decoy commands completed before corruption starts; range 0..255
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  CMD_W  opcode
- cmd_len  in  LEN_W  number of beats (0 legal)
- keyinput  in  KEY_W  unlock key, sampled only at accept
- out_valid  out  1  beat present
- out_ready  in  1  beat consumed when valid&ready
- out_data  out  OUT_W  beat payload
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at command completion

## Operation
- States: IDLE, DECODE, EXEC, DONE (genuine); DECODE_D, EXEC_D, DONE_D (decoy). Any illegal encoding goes to IDLE next cycle.
- IDLE: cmd_ready=1. On accept, latch op and len. Go to DECODE if keyinput==KEY_VAL, otherwise to DECODE_D.
- DECODE/DECODE_D: one cycle. Load beat index to 0. If len==0, go to DONE/DONE_D; otherwise go to EXEC/EXEC_D.
- EXEC/EXEC_D: out_valid=1.
  - Genuine data = (op << LEN_W) | idx, zero-extended to OUT_W.
  - On out_ready, idx increments. On the beat with idx==len-1, go to DONE/DONE_D.
  - While out_ready=0, out_valid and out_data hold stable and the state holds.
- Decoy corruption: in EXEC_D, out_data = ~genuine if decoy_cnt >= CORRUPT_AFTER, else genuine.
- DONE/DONE_D: done=1 for one cycle, then go to IDLE.
  - DONE_D increments decoy_cnt, saturating at CORRUPT_AFTER.
  - The counter is not cleared by a later correct key; only reset clears it.
- Genuine and decoy paths have the same cycle timing, and busy/cmd_ready/done are identical on both.
- cmd_valid outside IDLE is ignored. keyinput changes after accept have no effect.

## Timing
- Reset (rst=0 at a clock edge): state=IDLE, idx=0, decoy_cnt=0, cmd_ready=1 from the first cycle after reset; out_valid=0, out_data=0, busy=0, done=0.
- A reset mid-burst aborts with no done pulse. The next cycle is IDLE.
- Accept at edge T. DECODE during T+1. First beat valid during T+2.
- With out_ready held high, beats occupy T+2..T+1+len, done pulses at T+2+len, and cmd_ready=1 again at T+3+len.
- With len=0: DECODE at T+1, done at T+2, IDLE at T+3.
- Each out_ready=0 cycle during EXEC adds exactly one cycle.
- cmd_ready is registered from state, with no combinational path from cmd_valid. out_data is a function of registered state/op/idx/decoy_cnt only.

## Structure
- Package keyed_cmd_seq_pkg:
  - state enum, with explicit encoding and decoy states distinct from genuine states
  - function format_beat(op, idx)
  - localparam CNT_W = $clog2(CORRUPT_AFTER+1), minimum 1
- One sub-module, keyed_cmd_seq_beat_ctr: LEN_W index register with load/advance/last outputs, shared by both paths.

## Test plan
- Correct key 8'hA5, op=4'h3, len=3, out_ready=1 -> beats 8'h30, 8'h31, 8'h32 at T+2..T+4; done at T+5; cmd_ready at T+6.
- Wrong key 8'h00, six commands op=4'h1, len=2 -> first five give 8'h10, 8'h11; the sixth gives 8'hEF, 8'hEE. Busy/done timing matches the genuine path.
- After saturation, correct key op=4'h2, len=1 -> 8'h20 (genuine unaffected); the next wrong-key command is still inverted.
- Backpressure: out_ready low for 2 cycles on the second beat of len=3 -> out_data holds 8'hx1; done is delayed by exactly 2 cycles.
- len=0 -> no out_valid; done at T+2; no data beats.
- rst=0 during the second beat of a len=4 burst -> IDLE, out_valid=0, no done, decoy_cnt=0, cmd_ready=1 on the next cycle.
